// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants and FSM encoding for the movement scheduler
//   Collision bit indices, player selects, scheduler state encoding and the
//   "fully blocked" collision value substituted on an ack timeout.
package game_pkg;

  localparam int COL_UP    = 0;
  localparam int COL_DOWN  = 1;
  localparam int COL_RIGHT = 2;
  localparam int COL_LEFT  = 3;

  localparam logic SEL_BLUE = 1'b0;
  localparam logic SEL_RED  = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT_B = 3'd1;
  localparam logic [2:0] ST_STEP_B = 3'd2;
  localparam logic [2:0] ST_WAIT_R = 3'd3;
  localparam logic [2:0] ST_STEP_R = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_WAIT_B = ST_WAIT_B,
    S_STEP_B = ST_STEP_B,
    S_WAIT_R = ST_WAIT_R,
    S_STEP_R = ST_STEP_R
  } state_e;

  localparam logic [3:0] COL_BLOCKED_ALL = 4'b1111;

endpackage

// File: rtl/move_scheduler_if.sv
// rtl/move_scheduler_if.sv - handshake to the shared collision checker
//   col_req   : scheduler -> checker, query in progress
//   col_sel   : scheduler -> checker, 0 = blue, 1 = red
//   col_ack   : checker -> scheduler, col_state valid this cycle
//   col_state : checker -> scheduler, [0] up [1] down [2] right [3] left
interface move_scheduler_if;
  logic       col_req;
  logic       col_sel;
  logic       col_ack;
  logic [3:0] col_state;

  modport master (output col_req, output col_sel, input col_ack, input col_state);
  modport slave  (input col_req, input col_sel, output col_ack, output col_state);
endinterface

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running game tick divider
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : high for one cycle while the counter sits at TICK_DIV-1
module tick_divider #(
  parameter int TICK_DIV = 833333,
  parameter int CNT_W    = 20
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - per-tick blue/red collision query and step sequencer
//   clk, rst_n  : clock, asynchronous active-low reset
//   pause       : blocks new rounds from starting
//   chk         : master side of the collision checker handshake
//   blue_col    : latched blue collision state
//   red_col     : latched red collision state
//   blue_step   : one-cycle blue move enable
//   red_step    : one-cycle red move enable
//   round_done  : one-cycle pulse coincident with red_step
//   busy        : a round is in progress
//   overrun_cnt : saturating count of ticks that arrived while busy
//   timeout_err : sticky, set on any col_ack timeout
module move_scheduler
  import game_pkg::*;
#(
  parameter int TICK_DIV = 833333,
  parameter int CNT_W    = 20,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pause,
  move_scheduler_if.master    chk,
  output logic [3:0]          blue_col,
  output logic [3:0]          red_col,
  output logic                blue_step,
  output logic                red_step,
  output logic                round_done,
  output logic                busy,
  output logic [7:0]          overrun_cnt,
  output logic                timeout_err
);

  logic       tick;
  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] blue_col_q, blue_col_d;
  logic [3:0] red_col_q, red_col_d;
  logic [7:0] overrun_q, overrun_d;
  logic       timeout_q, timeout_d;
  logic       expired;

  tick_divider #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // wait_q counts completed WAIT cycles; the TIMEOUT-th WAIT cycle without an
  // ack is the last one, so a wait lasts at most TIMEOUT cycles.
  assign expired = (wait_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    blue_col_d = blue_col_q;
    red_col_d  = red_col_q;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (tick && !pause) begin
          state_d = S_WAIT_B;
          wait_d  = '0;
        end
      end
      S_WAIT_B: begin
        if (chk.col_ack) begin
          blue_col_d = chk.col_state;
          state_d    = S_STEP_B;
        end else if (expired) begin
          blue_col_d = COL_BLOCKED_ALL;
          timeout_d  = 1'b1;
          state_d    = S_STEP_B;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_STEP_B: begin
        state_d = S_WAIT_R;
        wait_d  = '0;
      end
      S_WAIT_R: begin
        if (chk.col_ack) begin
          red_col_d = chk.col_state;
          state_d   = S_STEP_R;
        end else if (expired) begin
          red_col_d = COL_BLOCKED_ALL;
          timeout_d = 1'b1;
          state_d   = S_STEP_R;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_STEP_R: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Ticks are never queued; one landing in any non-IDLE state (including
    // STEP_R) is only counted.
    if (tick && (state_q != S_IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      blue_col_q <= '0;
      red_col_q  <= '0;
      overrun_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      blue_col_q <= blue_col_d;
      red_col_q  <= red_col_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign chk.col_req  = (state_q == S_WAIT_B) || (state_q == S_WAIT_R);
  assign chk.col_sel  = (state_q == S_WAIT_R) ? SEL_RED : SEL_BLUE;
  assign blue_step    = (state_q == S_STEP_B);
  assign red_step     = (state_q == S_STEP_R);
  assign round_done   = (state_q == S_STEP_R);
  assign busy         = (state_q != S_IDLE);
  assign blue_col     = blue_col_q;
  assign red_col      = red_col_q;
  assign overrun_cnt  = overrun_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - scoreboard bench for move_scheduler
module tb_move_scheduler;

  localparam int TICK_DIV = 10;
  localparam int CNT_W    = 4;
  localparam int TIMEOUT  = 8;
  localparam int NO_ACK   = 255;

  typedef struct packed {
    logic       sel;
    logic [3:0] col;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] blue_col, red_col;
  logic       blue_step, red_step, round_done, busy, timeout_err;
  logic [7:0] overrun_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_ovr  = 0;
  exp_t sb_q[$];

  move_scheduler_if chk_if ();

  move_scheduler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pause       (pause),
    .chk         (chk_if),
    .blue_col    (blue_col),
    .red_col     (red_col),
    .blue_step   (blue_step),
    .red_step    (red_step),
    .round_done  (round_done),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every step pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (blue_step || red_step)) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_step", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("step_sel", {31'd0, red_step}, {31'd0, e.sel});
        check_val("step_col", red_step ? red_col : blue_col, e.col);
        check_val("round_done", round_done, e.sel);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req"}, chk_if.col_req, 0);
    check_val({tag, "_sel"}, chk_if.col_sel, 0);
    check_val({tag, "_bcol"}, blue_col, 0);
    check_val({tag, "_rcol"}, red_col, 0);
    check_val({tag, "_steps"}, {blue_step, red_step, round_done}, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_ovr"}, overrun_cnt, 0);
    check_val({tag, "_terr"}, timeout_err, 0);
  endtask

  // After reset release the first round must start on the first tick,
  // TICK_DIV cycles later; stray acks while IDLE must be ignored.
  task automatic expect_start();
    for (int i = 1; i < TICK_DIV; i++) begin
      chk_if.col_ack   = (i < TICK_DIV - 1);
      chk_if.col_state = 4'b0110;
      @(negedge clk);
      check_val("start_idle_req", chk_if.col_req, 0);
      check_val("stray_ack_bcol", blue_col, 0);
      check_val("stray_ack_step", blue_step, 0);
    end
    chk_if.col_ack = 1'b0;
    @(negedge clk);
    check_val("start_req", chk_if.col_req, 1);
    check_val("start_sel", chk_if.col_sel, 0);
  endtask

  // Act as the collision checker for one query: ack in WAIT cycle `delay`
  // (0 = first), or never when delay >= TIMEOUT. gap >= 0 demands col_req
  // rise exactly that many cycles after the call.
  task automatic serve(input logic sel, input int delay, input logic [3:0] st, input int gap);
    int   n;
    int   cycles;
    bit   to;
    exp_t e;
    n = 0;
    while (!chk_if.col_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("req_seen", chk_if.col_req, 1);
    if (!chk_if.col_req) return;
    if (gap >= 0) check_val("req_gap", n, gap);
    to     = (delay >= TIMEOUT);
    cycles = to ? TIMEOUT : delay + 1;
    e.sel  = sel;
    e.col  = to ? 4'b1111 : st;
    sb_q.push_back(e);
    for (int i = 0; i < cycles; i++) begin
      check_val("req_hold", chk_if.col_req, 1);
      check_val("sel_hold", chk_if.col_sel, sel);
      if (i == delay) begin
        chk_if.col_ack   = 1'b1;
        chk_if.col_state = st;
      end else begin
        chk_if.col_ack   = 1'b0;
        chk_if.col_state = 4'($urandom);
      end
      @(negedge clk);
      chk_if.col_ack = 1'b0;
    end
    check_val(sel ? "red_step_time" : "blue_step_time", sel ? red_step : blue_step, 1);
    check_val("req_drop", chk_if.col_req, 0);
    if (sel) begin
      @(negedge clk);
      check_val("idle_after_round", busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_if.col_ack   = 1'b0;
    chk_if.col_state = 4'b0000;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Nominal round, immediate acks.
    expect_start();
    serve(1'b0, 0, 4'b0010, 0);
    serve(1'b1, 0, 4'b0100, 1);
    check_val("nom_bcol", blue_col, 4'b0010);
    check_val("nom_rcol", red_col, 4'b0100);

    // Delayed blue ack.
    serve(1'b0, 2, 4'b0001, -1);
    serve(1'b1, 0, 4'b1000, 1);
    check_val("dly_terr", timeout_err, 0);
    check_val("dly_ovr", overrun_cnt, exp_ovr);

    // Blue times out; red acks in its last allowed cycle (ack wins).
    serve(1'b0, NO_ACK, 4'b0000, -1);
    serve(1'b1, TIMEOUT - 1, 4'b1001, 1);
    exp_ovr++;
    check_val("to_terr", timeout_err, 1);
    check_val("to_ovr", overrun_cnt, exp_ovr);
    serve(1'b0, 1, 4'b0101, -1);
    serve(1'b1, 3, 4'b1010, 1);
    check_val("to_terr_sticky", timeout_err, 1);
    check_val("to_bcol_after", blue_col, 4'b0101);

    // Tick lands exactly on STEP_R: counted as overrun, no new round.
    serve(1'b0, 6, 4'b0011, -1);
    serve(1'b1, 0, 4'b1100, 1);
    exp_ovr++;
    check_val("edge_ovr", overrun_cnt, exp_ovr);
    repeat (8) begin
      @(negedge clk);
      check_val("edge_no_round", chk_if.col_req, 0);
    end

    // Pause while idle, then pause asserted mid-round.
    pause = 1'b1;
    repeat (3 * TICK_DIV) begin
      @(negedge clk);
      check_val("pause_req", chk_if.col_req, 0);
    end
    check_val("pause_ovr", overrun_cnt, exp_ovr);
    pause = 1'b0;
    serve(1'b0, 0, 4'b0110, -1);
    pause = 1'b1;
    serve(1'b1, 2, 4'b0111, 1);
    repeat (25) begin
      @(negedge clk);
      check_val("pause2_req", chk_if.col_req, 0);
    end
    pause = 1'b0;
    serve(1'b0, 0, 4'b1110, -1);
    serve(1'b1, 0, 4'b1101, 1);
    check_val("pause_ovr_end", overrun_cnt, exp_ovr);

    // Saturation: every all-timeout round drops exactly one tick.
    for (int r = 0; r < 300; r++) begin
      serve(1'b0, NO_ACK, 4'b0000, -1);
      serve(1'b1, NO_ACK, 4'b0000, 1);
      if (exp_ovr < 255) exp_ovr++;
      check_val("sat_ovr", overrun_cnt, exp_ovr);
    end
    check_val("sat_final", overrun_cnt, 255);

    // Asynchronous reset in WAIT_R.
    serve(1'b0, 0, 4'b0011, -1);
    @(negedge clk);
    check_val("pre_rst_sel", chk_if.col_sel, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    expect_start();
    serve(1'b0, 0, 4'b0010, 0);
    serve(1'b1, 0, 4'b0100, 1);
    check_val("post_rst_bcol", blue_col, 4'b0010);
    check_val("post_rst_rcol", red_col, 4'b0100);
    check_val("post_rst_ovr", overrun_cnt, 0);
    check_val("post_rst_terr", timeout_err, 0);

    check_val("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
